// File: rtl/dp_hpd_detector.sv
// Hot-plug-detect qualifier: synchronizes the raw HPD pin, qualifies plug/unplug
// over T_CONNECT cycles and reports in-range low pulses as single-cycle IRQs.
module dp_hpd_detector #(
    parameter int SYNC_STAGES = 2,
    parameter int T_IRQ_MIN   = 50000,
    parameter int T_IRQ_MAX   = 100000,
    parameter int T_CONNECT   = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic HPD_Signal,
    output logic HPD_Detect,
    output logic HPD_IRQ
);

    localparam int CNT_W = $clog2(T_CONNECT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_CONNECT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(T_CONNECT);
    localparam logic [CNT_W-1:0] IRQ_MIN  = CNT_W'(T_IRQ_MIN);
    localparam logic [CNT_W-1:0] IRQ_MAX  = CNT_W'(T_IRQ_MAX);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("dp_hpd_detector: SYNC_STAGES must be at least 2");
    end
    if (!(T_IRQ_MIN >= 1 && T_IRQ_MIN <= T_IRQ_MAX && T_IRQ_MAX < T_CONNECT - 1)) begin : g_bad_timing
        $error("dp_hpd_detector: need 1 <= T_IRQ_MIN <= T_IRQ_MAX < T_CONNECT-1");
    end

    typedef enum logic [1:0] {
        DISCONNECTED = 2'd0,
        PLUG_WAIT    = 2'd1,
        CONNECTED    = 2'd2,
        LOW_WAIT     = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_SAT) ? CNT_SAT : v + CNT_ONE;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hpd_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   det_q, det_d;
    logic                   irq_q, irq_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], HPD_Signal};
        end
    end

    assign hpd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISCONNECTED;
            cnt_q   <= '0;
            det_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        det_d   = det_q;
        irq_d   = 1'b0;
        unique case (state_q)
            DISCONNECTED: begin
                det_d = 1'b0;
                if (hpd_s) begin
                    state_d = PLUG_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PLUG_WAIT: begin
                if (!hpd_s) begin
                    state_d = DISCONNECTED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = CONNECTED;
                    cnt_d   = '0;
                    det_d   = 1'b1;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            CONNECTED: begin
                if (!hpd_s) begin
                    state_d = LOW_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            LOW_WAIT: begin
                if (hpd_s) begin
                    // cnt_q holds the number of low samples seen in this pulse
                    state_d = CONNECTED;
                    cnt_d   = '0;
                    irq_d   = (cnt_q >= IRQ_MIN) && (cnt_q <= IRQ_MAX);
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DISCONNECTED;
                    cnt_d   = '0;
                    det_d   = 1'b0;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = DISCONNECTED;
                cnt_d   = '0;
                det_d   = 1'b0;
            end
        endcase
    end

    assign HPD_Detect = det_q;
    assign HPD_IRQ    = irq_q;

endmodule

// File: tb/tb_dp_hpd_detector.sv
// Bench for dp_hpd_detector: directed scenarios plus random HPD waveforms, all
// checked against a run-length model of the pin after synchronizer delay.
module tb_dp_hpd_detector;

    localparam int SS    = 2;
    localparam int TMIN  = 5;
    localparam int TMAX  = 10;
    localparam int TCONN = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic HPD_Signal = 1'b0;
    logic HPD_Detect;
    logic HPD_IRQ;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pin delay line, connection flag and run lengths
    logic [SS-1:0] m_pipe;
    bit  m_conn;
    int  m_hi, m_lo;
    logic m_det, m_irq;

    dp_hpd_detector #(
        .SYNC_STAGES(SS), .T_IRQ_MIN(TMIN), .T_IRQ_MAX(TMAX), .T_CONNECT(TCONN)
    ) dut (
        .clk(clk), .rst(rst), .HPD_Signal(HPD_Signal),
        .HPD_Detect(HPD_Detect), .HPD_IRQ(HPD_IRQ)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pipe = '0; m_conn = 0; m_hi = 0; m_lo = 0; m_det = 0; m_irq = 0;
    endtask

    task automatic model_edge(input logic pin);
        logic s;
        s = m_pipe[SS-1];
        m_pipe = {m_pipe[SS-2:0], pin};
        m_irq = 0;
        if (!m_conn) begin
            m_hi = s ? m_hi + 1 : 0;
            if (m_hi == TCONN) begin m_conn = 1; m_hi = 0; m_lo = 0; end
        end else if (!s) begin
            m_lo++;
            if (m_lo == TCONN) begin m_conn = 0; m_lo = 0; m_hi = 0; end
        end else begin
            m_irq = (m_lo >= TMIN && m_lo <= TMAX);
            m_lo = 0;
        end
        m_det = m_conn;
    endtask

    task automatic tick(input logic v);
        HPD_Signal = v;
        @(posedge clk);
        if (!rst) model_edge(v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        HPD_Signal = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (HPD_Detect !== 1'b0 || HPD_IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: detect=%b irq=%b required 0/0", HPD_Detect, HPD_IRQ);
        end
        do_reset();
    endtask

    task automatic test_plug();
        int rise_at = -1;
        int irqs = 0;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            tick(1'b1);
            n_cmp++;
            if (HPD_Detect !== m_det || HPD_IRQ !== m_irq) begin
                n_err++;
                $display("FAIL plug_cycle%0d: detect=%b irq=%b required %b/%b", k, HPD_Detect, HPD_IRQ, m_det, m_irq);
            end
            if (HPD_Detect === 1'b1 && rise_at < 0) rise_at = k;
            if (HPD_IRQ !== 1'b0) irqs++;
        end
        n_cmp++;
        if (rise_at !== SS + TCONN || irqs !== 0) begin
            n_err++;
            $display("FAIL plug_latency: rise edge %0d irqs %0d required %0d/0", rise_at, irqs, SS + TCONN);
        end
    endtask

    task automatic test_glitch();
        int rise_at = -1;
        do_reset();
        for (int k = 1; k <= 55; k++) begin
            tick((k == 16) ? 1'b0 : 1'b1);
            n_cmp++;
            if (HPD_Detect !== m_det || HPD_IRQ !== m_irq) begin
                n_err++;
                $display("FAIL glitch_cycle%0d: detect=%b irq=%b required %b/%b", k, HPD_Detect, HPD_IRQ, m_det, m_irq);
            end
            if (HPD_Detect === 1'b1 && rise_at < 0) rise_at = k;
        end
        // re-rise driven on edge 17 reaches hpd_s and is first sampled on edge 19
        n_cmp++;
        if (rise_at !== 17 + SS + TCONN - 1) begin
            n_err++;
            $display("FAIL glitch_latency: rise edge %0d required %0d", rise_at, 17 + SS + TCONN - 1);
        end
    endtask

    task automatic test_irq();
        int widths[4] = '{4, 5, 10, 11};
        int irqs = 0;
        int det_drop = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < widths[p] + 4; k++) begin
                tick((k < widths[p]) ? 1'b0 : 1'b1);
                n_cmp++;
                if (HPD_Detect !== m_det || HPD_IRQ !== m_irq) begin
                    n_err++;
                    $display("FAIL irq_w%0d_c%0d: detect=%b irq=%b required %b/%b", widths[p], k, HPD_Detect, HPD_IRQ, m_det, m_irq);
                end
                if (HPD_IRQ === 1'b1) irqs++;
                if (HPD_Detect !== 1'b1) det_drop++;
            end
        end
        n_cmp++;
        if (irqs !== 2 || det_drop !== 0) begin
            n_err++;
            $display("FAIL irq_count: irqs %0d detect_drops %0d required 2/0", irqs, det_drop);
        end
    endtask

    task automatic test_back_to_back();
        int irqs = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 6; k++) begin
                tick((k < 5) ? 1'b0 : 1'b1);
                n_cmp++;
                if (HPD_Detect !== m_det || HPD_IRQ !== m_irq) begin
                    n_err++;
                    $display("FAIL b2b_p%0d_c%0d: detect=%b irq=%b required %b/%b", p, k, HPD_Detect, HPD_IRQ, m_det, m_irq);
                end
                if (HPD_IRQ === 1'b1) irqs++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b1);
            if (HPD_IRQ === 1'b1) irqs++;
        end
        n_cmp++;
        if (irqs !== 4) begin
            n_err++;
            $display("FAIL b2b_count: irqs %0d required 4", irqs);
        end
    endtask

    task automatic test_unplug();
        int fall_at = -1;
        int irqs = 0;
        for (int k = 0; k < 25; k++) begin
            tick((k < 19) ? 1'b0 : 1'b1);
            if (HPD_IRQ === 1'b1) irqs++;
            if (HPD_Detect !== 1'b1) fall_at = 0;
        end
        n_cmp++;
        if (fall_at !== -1 || irqs !== 0) begin
            n_err++;
            $display("FAIL unplug_19low: detect_dropped=%0d irqs %0d required none/0", fall_at + 1, irqs);
        end
        fall_at = -1;
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0);
            n_cmp++;
            if (HPD_Detect !== m_det || HPD_IRQ !== m_irq) begin
                n_err++;
                $display("FAIL unplug_cycle%0d: detect=%b irq=%b required %b/%b", k, HPD_Detect, HPD_IRQ, m_det, m_irq);
            end
            if (HPD_Detect === 1'b0 && fall_at < 0) fall_at = k;
            if (HPD_IRQ === 1'b1) irqs++;
        end
        n_cmp++;
        if (fall_at !== SS + TCONN || irqs !== 0) begin
            n_err++;
            $display("FAIL unplug_latency: fall edge %0d irqs %0d required %0d/0", fall_at, irqs, SS + TCONN);
        end
    endtask

    task automatic test_reset_mid();
        int rise_at = -1;
        int irqs = 0;
        for (int k = 0; k < 4; k++) tick(1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (HPD_Detect !== 1'b0 || HPD_IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_async: detect=%b irq=%b required 0/0", HPD_Detect, HPD_IRQ);
        end
        model_reset();
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick(1'b1);
            n_cmp++;
            if (HPD_Detect !== m_det || HPD_IRQ !== m_irq) begin
                n_err++;
                $display("FAIL reset_mid_cycle%0d: detect=%b irq=%b required %b/%b", k, HPD_Detect, HPD_IRQ, m_det, m_irq);
            end
            if (HPD_Detect === 1'b1 && rise_at < 0) rise_at = k;
            if (HPD_IRQ === 1'b1) irqs++;
        end
        n_cmp++;
        if (rise_at !== SS + TCONN || irqs !== 0) begin
            n_err++;
            $display("FAIL reset_mid_requal: rise edge %0d irqs %0d required %0d/0", rise_at, irqs, SS + TCONN);
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b1;
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            len = (seg % 3 == 0) ? $urandom_range(1, 25) : $urandom_range(1, 13);
            for (int k = 0; k < len; k++) begin
                tick(lvl);
                n_cmp++;
                if (HPD_Detect !== m_det || HPD_IRQ !== m_irq) begin
                    n_err++;
                    $display("FAIL random_s%0d_c%0d: detect=%b irq=%b required %b/%b", seg, k, HPD_Detect, HPD_IRQ, m_det, m_irq);
                end
            end
            lvl = ~lvl;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_plug();
        test_irq();
        test_back_to_back();
        test_unplug();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
